// File: rtl/ps2_rx_deserializer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ps2_rx_deserializer                                           |
// | Brief    : PS/2 keyboard receiver; synchronizes and glitch-filters the   |
// |            PS/2 clock and turns 11-bit frames into 8-bit scan codes.     |
// | Options  : define PS2_RX_TIMEOUT_EN to abort stalled partial frames.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ps2_rx_deserializer #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int c_FILT_W = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   w_clk_s;
  logic                   w_data_s;

  logic                   r_clk_filt;
  logic                   r_clk_filt_d;
  logic [c_FILT_W-1:0]    r_filt_cnt;
  logic                   w_fall;

  state_t                 r_state;
  logic [3:0]             r_bitcnt;
  logic [7:0]             r_shreg;
  logic                   r_perr;
  logic                   w_to_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];

  // Filtered clock only follows the synced clock after FILTER_LEN
  // consecutive disagreeing samples; any agreeing sample restarts the run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_filt   <= 1'b1;
      r_clk_filt_d <= 1'b1;
      r_filt_cnt   <= '0;
    end else begin
      r_clk_filt_d <= r_clk_filt;
      if (w_clk_s == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == c_FILT_W'(FILTER_LEN - 1)) begin
        r_clk_filt <= w_clk_s;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + c_FILT_W'(1);
      end
    end
  end

  assign w_fall = r_clk_filt_d & ~r_clk_filt;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_TO_W-1:0] r_to_cnt;

  // A falling edge always wins over an expiring count in the same cycle.
  assign w_to_hit = (r_state != ST_IDLE) && !w_fall &&
                    (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (w_fall || r_state == ST_IDLE || w_to_hit) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + c_TO_W'(1);
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_bitcnt   <= 4'd0;
      r_shreg    <= 8'h00;
      r_perr     <= 1'b0;
      scan_code  <= 8'h00;
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (w_fall) begin
        case (r_state)
          ST_IDLE: begin
            // A high data line here is a stray edge, not a start bit.
            if (!w_data_s) begin
              r_state  <= ST_DATA;
              r_bitcnt <= 4'd0;
            end
          end
          ST_DATA: begin
            r_shreg  <= {w_data_s, r_shreg[7:1]};
            r_bitcnt <= r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) begin
              r_state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            r_perr  <= ~^{r_shreg, w_data_s};
            r_state <= ST_STOP;
          end
          ST_STOP: begin
            if (!w_data_s) begin
              frame_err <= 1'b1;
            end else if (r_perr) begin
              parity_err <= 1'b1;
            end else begin
              scan_code  <= r_shreg;
              code_valid <= 1'b1;
            end
            r_state  <= ST_IDLE;
            r_bitcnt <= 4'd0;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end else if (w_to_hit) begin
        r_state   <= ST_IDLE;
        r_bitcnt  <= 4'd0;
        frame_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_deserializer.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for ps2_rx_deserializer: directed and random PS/2 frames scored
// against a frame-level reference model of the receiver.
module tb_ps2_rx_deserializer;

  localparam int HALF = 30;
  localparam int TMO  = 2000;
  localparam int LAT  = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       parity_err;
  logic       frame_err;

  ps2_rx_deserializer #(
    .SYNC_STAGES(2),
    .FILTER_LEN(4),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .scan_code(scan_code),
    .code_valid(code_valid),
    .parity_err(parity_err),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         kind;
    logic [7:0] code;
    longint     at;
  } ev_t;

  ev_t        obs[$];
  logic [7:0] model_code = 8'h00;
  logic [7:0] held = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: records pulses, checks exclusivity and scan_code stability.
  always @(negedge clk) begin
    if (reset) begin
      held = 8'h00;
    end else begin
      if (code_valid || parity_err || frame_err) begin
        check("onehot", $countones({code_valid, parity_err, frame_err}), 1);
        obs.push_back('{code_valid ? 1 : (parity_err ? 2 : 3), scan_code, cyc});
        if (code_valid) held = scan_code;
      end else begin
        check("hold", {24'h0, scan_code}, {24'h0, held});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive_bit(input bit b, input bit glitch, output longint fall_at);
    ps2_data = b;
    tick(8);
    if (glitch) begin
      ps2_clk = 1'b0;
      tick(2);
      ps2_clk = 1'b1;
      tick(HALF - 10);
    end else begin
      tick(HALF - 8);
    end
    ps2_clk = 1'b0;
    fall_at = cyc;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] b, input bit p, input bit stop,
                           input int glitch_bit, input int nbits, output longint last_fall);
    logic [10:0] bits;
    bits = {stop, p, b, 1'b0};
    last_fall = 0;
    for (int i = 0; i < nbits; i++) drive_bit(bits[i], i == glitch_bit, last_fall);
    ps2_data = 1'b1;
  endtask

  task automatic expect_event(input int kind, input logic [7:0] code, input longint at, input int tol);
    ev_t    e;
    longint d;
    if (obs.size() == 0) begin
      check("pulse_seen", 0, 1);
    end else begin
      e = obs.pop_front();
      check("kind", e.kind, kind);
      d = e.at - at;
      check("latency_dev", (d >= -tol && d <= tol) ? 32'd0 : 32'(d), 0);
      if (kind == 1) model_code = code;
      check("scan_code", {24'h0, e.code}, {24'h0, model_code});
    end
    check("extra_pulses", obs.size(), 0);
  endtask

  // Reference: parity and outcome derive from the transmitted bits alone.
  task automatic run_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input int glitch_bit);
    bit     p;
    int     kind;
    longint fa;
    p = (($countones(b) % 2) == 0) ^ bad_par;
    if (bad_stop) kind = 3;
    else if (($countones({b, p}) % 2) == 0) kind = 2;
    else kind = 1;
    send_bits(b, p, !bad_stop, glitch_bit, 11, fa);
    tick(40);
    expect_event(kind, b, fa + LAT, 1);
    check("scan_code_now", {24'h0, scan_code}, {24'h0, model_code});
  endtask

  task automatic idle_glitch();
    ps2_clk = 1'b0;
    tick(2);
    ps2_clk = 1'b1;
    tick(20);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    longint fa;
    logic [7:0] b;
    int r;

    reset = 1'b1;
    tick(5);
    check("rst_scan_code", {24'h0, scan_code}, 0);
    check("rst_code_valid", code_valid, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_frame_err", frame_err, 0);
    reset = 1'b0;
    tick(20);

    run_frame(8'h1C, 0, 0, -1);
    run_frame(8'hF0, 0, 0, -1);
    run_frame(8'h1C, 0, 0, -1);
    run_frame(8'h1C, 1, 0, -1);
    run_frame(8'h29, 0, 1, -1);
    run_frame(8'h29, 0, 0, -1);

    idle_glitch();
    check("idle_glitch_quiet", obs.size(), 0);
    run_frame(8'h5A, 0, 0, 4);
    run_frame(8'hA5, 0, 0, 0);

    // Partial frame: start + 4 data bits, then silence.
    send_bits(8'h29, 1'b0, 1'b1, -1, 5, fa);
    tick(2500);
`ifdef PS2_RX_TIMEOUT_EN
    expect_event(3, 8'h00, fa + TMO + LAT, 2);
    run_frame(8'h29, 0, 0, -1);
`else
    check("no_timeout_pulse", obs.size(), 0);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    model_code = 8'h00;
    tick(20);
    run_frame(8'h29, 0, 0, -1);
`endif

    // Reset in the middle of a frame drops it silently.
    send_bits(8'h77, 1'b0, 1'b1, -1, 4, fa);
    reset = 1'b1;
    tick(3);
    check("midrst_scan_code", {24'h0, scan_code}, 0);
    check("midrst_pulses", {code_valid, parity_err, frame_err}, 0);
    check("midrst_no_event", obs.size(), 0);
    model_code = 8'h00;
    reset = 1'b0;
    tick(20);
    run_frame(8'h33, 0, 0, -1);

    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom);
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 4) == 0) idle_glitch();
      run_frame(b, r < 2, r >= 2 && r < 4,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1);
    end

    tick(50);
    check("drain", obs.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
